apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer_pkg.sv | 56 +++++
 rtl/apb_timer_prescaler.sv | 34 +++
 rtl/apb_timer.sv | 161 ++++++++++++++++
 tb/tb_apb_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, bit indices,
// register-select type and the address decode helper.
package apb_timer_pkg;

  localparam int DATA_W  = 32;
  localparam int PRESC_W = 8;

  // Byte offsets of the registers; only address bits [4:2] are decoded.
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_LOAD   = 5'h04;
  localparam logic [4:0] OFF_COUNT  = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_PRESC  = 5'h10;

  // Word indices derived from the byte offsets.
  localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_LOAD   = OFF_LOAD[4:2];
  localparam logic [2:0] IDX_COUNT  = OFF_COUNT[4:2];
  localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_PRESC  = OFF_PRESC[4:2];

  // CTRL bit positions.
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  // STATUS bit positions.
  localparam int STATUS_EXP = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_LOAD,
    SEL_COUNT,
    SEL_STATUS,
    SEL_PRESC
  } reg_sel_e;

  // Map a word index to a register; PRESC is only mapped when the
  // prescaler is built in, otherwise its offset behaves as unmapped.
  function automatic reg_sel_e decode_reg(input logic [2:0] idx,
                                          input logic       presc_present);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (idx)
      IDX_CTRL:   sel = SEL_CTRL;
      IDX_LOAD:   sel = SEL_LOAD;
      IDX_COUNT:  sel = SEL_COUNT;
      IDX_STATUS: sel = SEL_STATUS;
      IDX_PRESC:  sel = presc_present ? SEL_PRESC : SEL_NONE;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Clock prescaler for the APB timer: emits one tick every presc+1 clocks
// while enabled. The phase restarts from zero on 'restart' and is held at
// zero while disabled.
module apb_timer_prescaler
  import apb_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  logic [PRESC_W-1:0] phase;

  // A tick fires on the last phase of the period; a restart suppresses it
  // so the new period always starts cleanly.
  assign tick = en & ~restart & (phase == presc);

  // Phase counter wraps after presc, restarts on request, idles at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (restart || !en) begin
      phase <= '0;
    end else if (phase == presc) begin
      phase <= '0;
    end else begin
      phase <= phase + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB zero-wait-state down-counting timer with one-shot / auto-reload
// modes, sticky expiry flag (write-1-to-clear) and level interrupt.
// Optional prescaler enabled by defining APB_TIMER_PRESCALER_EN; without
// it the counter ticks on every clock while enabled.
module apb_timer
  import apb_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [DATA_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Prdata,
  output logic              irq
);

`ifdef APB_TIMER_PRESCALER_EN
  localparam logic HAS_PRESC = 1'b1;
`else
  localparam logic HAS_PRESC = 1'b0;
`endif

  // Register state
  logic              ctrl_en;
  logic              ctrl_auto;
  logic              ctrl_ie;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] count_val;
  logic              exp_flag;

  // Access decode
  reg_sel_e sel;
  logic     wr_en;
  logic     wr_ctrl;
  logic     wr_load;
  logic     wr_status;
  logic     tick;
  logic     expire;
  logic     unused_addr_bits;

  assign unused_addr_bits = ^{Paddr[DATA_W-1:5], Paddr[1:0]};

  assign sel       = decode_reg(Paddr[4:2], HAS_PRESC);
  assign wr_en     = Psel & Penable & Pwrite;
  assign wr_ctrl   = wr_en & (sel == SEL_CTRL);
  assign wr_load   = wr_en & (sel == SEL_LOAD);
  assign wr_status = wr_en & (sel == SEL_STATUS);

`ifdef APB_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_val;
  logic               wr_presc;
  logic               presc_restart;

  assign wr_presc = wr_en & (sel == SEL_PRESC);

  // Restart the prescaler phase on a PRESC write or when EN goes 0 -> 1.
  assign presc_restart = wr_presc | (wr_ctrl & Pwdata[CTRL_EN] & ~ctrl_en);

  // PRESC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_val <= '0;
    end else if (wr_presc) begin
      presc_val <= Pwdata[PRESC_W-1:0];
    end
  end

  apb_timer_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl_en),
    .presc   (presc_val),
    .restart (presc_restart),
    .tick    (tick)
  );
`else
  assign tick = ctrl_en;
`endif

  // An expiry is a tick that finds the counter already at zero.
  assign expire = tick & (count_val == '0);

  // CTRL register: a software write takes precedence; otherwise a one-shot
  // expiry stops the timer by clearing EN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en   <= Pwdata[CTRL_EN];
      ctrl_auto <= Pwdata[CTRL_AUTO];
      ctrl_ie   <= Pwdata[CTRL_IE];
    end else if (expire && !ctrl_auto) begin
      ctrl_en   <= 1'b0;
    end
  end

  // LOAD register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_val <= '0;
    end else if (wr_load) begin
      load_val <= Pwdata;
    end
  end

  // COUNT: a LOAD write overrides any tick activity in the same cycle;
  // otherwise decrement, reload (auto) or hold at zero (one-shot).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_val <= '0;
    end else if (wr_load) begin
      count_val <= Pwdata;
    end else if (tick) begin
      if (count_val != '0) begin
        count_val <= count_val - {{(DATA_W-1){1'b0}}, 1'b1};
      end else if (ctrl_auto) begin
        count_val <= load_val;
      end
    end
  end

  // EXP flag: setting on expiry beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr_status && Pwdata[STATUS_EXP]) begin
      exp_flag <= 1'b0;
    end
  end

  // Interrupt is a pure function of registered state.
  assign irq = exp_flag & ctrl_ie;

  // Read mux: addressed register during a read, zero otherwise.
  always_comb begin
    Prdata = '0;
    if (Psel && !Pwrite) begin
      case (sel)
        SEL_CTRL: begin
          Prdata[CTRL_EN]   = ctrl_en;
          Prdata[CTRL_AUTO] = ctrl_auto;
          Prdata[CTRL_IE]   = ctrl_ie;
        end
        SEL_LOAD:   Prdata = load_val;
        SEL_COUNT:  Prdata = count_val;
        SEL_STATUS: Prdata[STATUS_EXP] = exp_flag;
`ifdef APB_TIMER_PRESCALER_EN
        SEL_PRESC:  Prdata[PRESC_W-1:0] = presc_val;
`endif
        default:    Prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: read stimulus pushes the expected read
// data and irq level; a monitor pops and compares during each read access
// phase. Prescaler checks are built when APB_TIMER_PRESCALER_EN is defined.
module tb_apb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Psel = 1'b0;
  logic        Penable = 1'b0;
  logic        Pwrite = 1'b0;
  logic [31:0] Paddr = '0;
  logic [31:0] Pwdata = '0;
  logic [31:0] Prdata;
  logic        irq;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_LOAD   = 32'h04;
  localparam logic [31:0] A_COUNT  = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_PRESC  = 32'h10;
  localparam logic [31:0] A_UNMAP  = 32'h14;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  apb_timer dut (
    .clk     (clk),
    .rst     (rst),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .irq     (irq)
  );

  // Monitor: compare every read access phase against the scoreboard head.
  always @(negedge clk) begin
    if (rst && Psel && Penable && !Pwrite) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: addr=%h data=%h with no expectation queued", Paddr, Prdata);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (Prdata !== mon_e.data) begin
          n_fail++;
          $display("FAIL %s data: got %h expected %h", mon_e.name, Prdata, mon_e.data);
        end
        n_checks++;
        if (irq !== mon_e.irq) begin
          n_fail++;
          $display("FAIL %s irq: got %b expected %b", mon_e.name, irq, mon_e.irq);
        end
      end
    end
  end

  // Tasks start and end #1 after a rising edge; each access takes 2 edges.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    Psel = 1'b1; Pwrite = 1'b1; Penable = 1'b0; Paddr = a; Pwdata = d;
    @(posedge clk); #1 Penable = 1'b1;
    @(posedge clk); #1 Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] d,
                          input logic i, input string nm);
    exp_t e;
    e.data = d; e.irq = i; e.name = nm;
    sb_q.push_back(e);
    Psel = 1'b1; Pwrite = 1'b0; Penable = 1'b0; Paddr = a;
    @(posedge clk); #1 Penable = 1'b1;
    @(posedge clk); #1 Psel = 1'b0; Penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    apb_read(A_CTRL,   32'h0, 1'b0, "rst_ctrl");
    apb_read(A_LOAD,   32'h0, 1'b0, "rst_load");
    apb_read(A_COUNT,  32'h0, 1'b0, "rst_count");
    apb_read(A_STATUS, 32'h0, 1'b0, "rst_status");
    apb_read(A_PRESC,  32'h0, 1'b0, "rst_presc");

    // Read-back, setup-only write ignored, timer decrement while running
    apb_write(A_LOAD, 32'h1234_5678);
    Psel = 1'b1; Pwrite = 1'b1; Penable = 1'b0; Paddr = A_LOAD; Pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 Psel = 1'b0; Pwrite = 1'b0;
    apb_read(A_LOAD,  32'h1234_5678, 1'b0, "rb_load");
    apb_read(A_COUNT, 32'h1234_5678, 1'b0, "rb_count");
    apb_write(A_CTRL, 32'hFFFF_FFFF);
    apb_read(A_CTRL,  32'h7, 1'b0, "rb_ctrl");
    apb_read(A_UNMAP, 32'h0, 1'b0, "rb_unmapped");
    apb_read(A_COUNT, 32'h1234_5673, 1'b0, "run_count5");
    apb_write(A_CTRL, 32'h0);
    apb_read(A_COUNT, 32'h1234_5670, 1'b0, "stop_count8");

    // One-shot expiry with IE
    apb_write(A_LOAD, 32'd3);
    apb_read(A_COUNT, 32'd3, 1'b0, "os_count3");
    apb_write(A_CTRL, 32'h5);
    apb_read(A_COUNT,  32'd2, 1'b0, "os_count2");
    apb_read(A_COUNT,  32'd0, 1'b0, "os_count0_noexp");
    apb_read(A_STATUS, 32'h1, 1'b1, "os_exp");
    apb_read(A_CTRL,   32'h4, 1'b1, "os_en_cleared");
    apb_read(A_COUNT,  32'd0, 1'b1, "os_count_hold");
    apb_write(A_LOAD, 32'd3);
    apb_write(A_CTRL, 32'h5);
    idle(1);
    apb_read(A_COUNT,  32'd1, 1'b1, "os_count1");
    apb_read(A_STATUS, 32'h1, 1'b1, "os_exp_again");
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, 1'b0, "os_w1c");

    // Auto-reload, IE off
    apb_write(A_LOAD, 32'd1);
    apb_write(A_CTRL, 32'h3);
    apb_read(A_COUNT,  32'd0, 1'b0, "ar_count0");
    apb_read(A_STATUS, 32'h1, 1'b0, "ar_exp_no_irq");
    idle(1);
    apb_read(A_COUNT,  32'd1, 1'b0, "ar_count1");
    apb_write(A_CTRL, 32'h0);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, 1'b0, "ar_cleared");

    // W1C on the expiry edge: set wins, later clear drops irq
    apb_write(A_LOAD, 32'd2);
    apb_write(A_CTRL, 32'h5);
    idle(1);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h1, 1'b1, "col_set_wins");
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, 1'b0, "col_later_clear");
    apb_read(A_CTRL,   32'h4, 1'b0, "col_en_cleared");

    // LOAD write on a reload edge, LOAD = 0 expiring every tick
    apb_write(A_LOAD, 32'd0);
    apb_write(A_CTRL, 32'h3);
    apb_write(A_LOAD, 32'd5);
    apb_read(A_COUNT,  32'd4, 1'b0, "ld_write_wins");
    apb_read(A_STATUS, 32'h1, 1'b0, "ld0_expired");
    apb_write(A_CTRL, 32'h0);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, 32'h0, 1'b0, "ld_cleared");

    // Reset during the access phase of a LOAD write while running
    apb_write(A_LOAD, 32'd100);
    apb_write(A_CTRL, 32'h7);
    Psel = 1'b1; Pwrite = 1'b1; Penable = 1'b0; Paddr = A_LOAD; Pwdata = 32'hA;
    @(posedge clk); #1 Penable = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1 Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    apb_read(A_CTRL,   32'h0, 1'b0, "mr_ctrl");
    apb_read(A_LOAD,   32'h0, 1'b0, "mr_load");
    apb_read(A_COUNT,  32'h0, 1'b0, "mr_count");
    apb_read(A_STATUS, 32'h0, 1'b0, "mr_status");
    apb_read(A_PRESC,  32'h0, 1'b0, "mr_presc");

`ifdef APB_TIMER_PRESCALER_EN
    // Prescaler: tick every 4 clocks, expiry 12 clocks after enable
    apb_write(A_PRESC, 32'd3);
    apb_read(A_PRESC, 32'd3, 1'b0, "ps_presc");
    apb_write(A_LOAD, 32'd2);
    apb_write(A_CTRL, 32'h1);
    apb_read(A_COUNT,  32'd2, 1'b0, "ps_c1");
    apb_read(A_COUNT,  32'd2, 1'b0, "ps_c3");
    apb_read(A_COUNT,  32'd1, 1'b0, "ps_c5");
    apb_read(A_STATUS, 32'h0, 1'b0, "ps_s7");
    apb_read(A_COUNT,  32'd0, 1'b0, "ps_c9");
    apb_read(A_STATUS, 32'h0, 1'b0, "ps_s11");
    apb_read(A_STATUS, 32'h1, 1'b0, "ps_s13");
    apb_read(A_CTRL,   32'h0, 1'b0, "ps_en_cleared");
`else
    // Offset 0x10 is unmapped: writes ignored
    apb_write(A_PRESC, 32'd3);
    apb_read(A_PRESC, 32'h0, 1'b0, "nops_presc");
`endif

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
